// File: rtl/hazard_if.sv
// Bundle between the 5-stage datapath and the hazard unit: pipeline register/timing
// fields flow in, stall/flush enables and forwarding selects flow out.
interface hazard_if #(
    parameter int AW     = 5,
    parameter int PERF_W = 32
);
    logic [AW-1:0]     rs_d, rt_d;
    logic [1:0]        tuse_rs_d, tuse_rt_d;
    logic              md_use_d;
    logic [AW-1:0]     rs_e, rt_e, waddr_e;
    logic [1:0]        tnew_e;
    logic [AW-1:0]     rt_m, waddr_m;
    logic [1:0]        tnew_m;
    logic [AW-1:0]     waddr_w;
    logic              start_e, is_div_e;

    logic              stall_f, stall_d, flush_e;
    logic [1:0]        fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic              fwd_rt_m;
    logic              mdu_busy, mdu_done;
    logic [PERF_W-1:0] stall_count;

    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_use_d,
        output rs_e, rt_e, waddr_e, tnew_e, rt_m, waddr_m, tnew_m, waddr_w,
        output start_e, is_div_e,
        input  stall_f, stall_d, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
        input  fwd_rt_m, mdu_busy, mdu_done, stall_count
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_use_d,
        input  rs_e, rt_e, waddr_e, tnew_e, rt_m, waddr_m, tnew_m, waddr_w,
        input  start_e, is_div_e,
        output stall_f, stall_d, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
        output fwd_rt_m, mdu_busy, mdu_done, stall_count
    );
endinterface

// File: rtl/hazard_unit_mdu.sv
// Tuse/Tnew hazard unit with forwarding selects, MDU busy scoreboard and a
// saturating stall-cycle counter. Register and counter widths come from hazard_if.
module hazard_unit_mdu #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  hz
);
    localparam int PERF_W = $bits(hz.stall_count);

    logic [CNT_W-1:0] cnt;

    logic rs_d_m, rs_d_w, rt_d_m, rt_d_w;
    logic rs_e_m, rs_e_w, rt_e_m, rt_e_w;
    logic rs_stall_e, rs_stall_m, rt_stall_e, rt_stall_m;
    logic data_stall, mdu_stall, stall;

    // An M-stage producer is only forwardable once its result exists (tnew_m == 0).
    assign rs_d_m = (hz.rs_d != '0) && (hz.rs_d == hz.waddr_m) && (hz.tnew_m == 2'd0);
    assign rs_d_w = (hz.rs_d != '0) && (hz.rs_d == hz.waddr_w);
    assign rt_d_m = (hz.rt_d != '0) && (hz.rt_d == hz.waddr_m) && (hz.tnew_m == 2'd0);
    assign rt_d_w = (hz.rt_d != '0) && (hz.rt_d == hz.waddr_w);
    assign rs_e_m = (hz.rs_e != '0) && (hz.rs_e == hz.waddr_m) && (hz.tnew_m == 2'd0);
    assign rs_e_w = (hz.rs_e != '0) && (hz.rs_e == hz.waddr_w);
    assign rt_e_m = (hz.rt_e != '0) && (hz.rt_e == hz.waddr_m) && (hz.tnew_m == 2'd0);
    assign rt_e_w = (hz.rt_e != '0) && (hz.rt_e == hz.waddr_w);

    assign hz.fwd_rs_d = rs_d_m ? 2'd1 : (rs_d_w ? 2'd2 : 2'd0);
    assign hz.fwd_rt_d = rt_d_m ? 2'd1 : (rt_d_w ? 2'd2 : 2'd0);
    assign hz.fwd_rs_e = rs_e_m ? 2'd1 : (rs_e_w ? 2'd2 : 2'd0);
    assign hz.fwd_rt_e = rt_e_m ? 2'd1 : (rt_e_w ? 2'd2 : 2'd0);
    assign hz.fwd_rt_m = (hz.rt_m != '0) && (hz.rt_m == hz.waddr_w);

    // The value is late when the consumer needs it sooner than the producer delivers it.
    assign rs_stall_e = (hz.rs_d != '0) && (hz.tuse_rs_d != 2'd3)
                        && (hz.rs_d == hz.waddr_e) && (hz.tuse_rs_d < hz.tnew_e);
    assign rs_stall_m = (hz.rs_d != '0) && (hz.tuse_rs_d != 2'd3)
                        && (hz.rs_d == hz.waddr_m) && (hz.tuse_rs_d < hz.tnew_m);
    assign rt_stall_e = (hz.rt_d != '0) && (hz.tuse_rt_d != 2'd3)
                        && (hz.rt_d == hz.waddr_e) && (hz.tuse_rt_d < hz.tnew_e);
    assign rt_stall_m = (hz.rt_d != '0) && (hz.tuse_rt_d != 2'd3)
                        && (hz.rt_d == hz.waddr_m) && (hz.tuse_rt_d < hz.tnew_m);

    assign data_stall = rs_stall_e | rs_stall_m | rt_stall_e | rt_stall_m;
    assign mdu_stall  = hz.md_use_d && (hz.mdu_busy || hz.start_e);
    assign stall      = data_stall | mdu_stall;

    assign hz.stall_d  = stall;
    assign hz.stall_f  = stall;
    assign hz.flush_e  = stall;
    assign hz.mdu_busy = (cnt != '0);
    assign hz.mdu_done = (cnt == CNT_W'(1));

    // A start while already busy is illegal and simply ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (hz.start_e && (cnt == '0)) begin
            cnt <= hz.is_div_e ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz.stall_count <= '0;
        end else if (stall && (hz.stall_count != '1)) begin
            hz.stall_count <= hz.stall_count + PERF_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_unit_mdu.sv
// Directed scenarios plus random traffic for hazard_unit_mdu, checked against a
// cycle-indexed behavioural model (MDU busy window, saturating stall tally).
module tb_hazard_unit_mdu;
    localparam int PERF_W = 4;
    localparam int MUL_L  = 5;
    localparam int DIV_L  = 10;
    localparam int SAT    = (1 << PERF_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_if #(.AW(5), .PERF_W(PERF_W)) hif ();

    hazard_unit_mdu #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model state: edge index, start edge of the current MDU op, its latency.
    int  edge_idx   = 0;
    int  op_start   = 0;
    int  op_lat     = 0;
    bit  op_valid   = 0;
    int  m_count    = 0;
    bit  m_stall    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int fwd_exp(int src, int wm, int tm, int ww);
        if (src != 0 && src == wm && tm == 0) return 1;
        if (src != 0 && src == ww) return 2;
        return 0;
    endfunction

    function automatic bit src_late(int src, int tuse);
        if (src == 0 || tuse == 3) return 0;
        if (src == int'(hif.waddr_e) && tuse < int'(hif.tnew_e)) return 1;
        if (src == int'(hif.waddr_m) && tuse < int'(hif.tnew_m)) return 1;
        return 0;
    endfunction

    function automatic bit model_busy();
        return op_valid && (edge_idx - op_start) < op_lat;
    endfunction

    function automatic bit model_done();
        return op_valid && (edge_idx - op_start) == op_lat - 1;
    endfunction

    task automatic model_reset();
        op_valid = 0;
        m_count  = 0;
    endtask

    task automatic set_idle();
        hif.rs_d = '0; hif.rt_d = '0; hif.tuse_rs_d = 2'd3; hif.tuse_rt_d = 2'd3;
        hif.md_use_d = 1'b0;
        hif.rs_e = '0; hif.rt_e = '0; hif.waddr_e = '0; hif.tnew_e = '0;
        hif.rt_m = '0; hif.waddr_m = '0; hif.tnew_m = '0; hif.waddr_w = '0;
        hif.start_e = 1'b0; hif.is_div_e = 1'b0;
    endtask

    task automatic check_outputs();
        bit busy;
        #1;
        busy    = model_busy();
        m_stall = src_late(int'(hif.rs_d), int'(hif.tuse_rs_d))
                | src_late(int'(hif.rt_d), int'(hif.tuse_rt_d))
                | (hif.md_use_d && (busy || hif.start_e));
        chk("stall_d", 32'(hif.stall_d), 32'(m_stall));
        chk("stall_f", 32'(hif.stall_f), 32'(m_stall));
        chk("flush_e", 32'(hif.flush_e), 32'(m_stall));
        chk("fwd_rs_d", 32'(hif.fwd_rs_d), fwd_exp(hif.rs_d, hif.waddr_m, hif.tnew_m, hif.waddr_w));
        chk("fwd_rt_d", 32'(hif.fwd_rt_d), fwd_exp(hif.rt_d, hif.waddr_m, hif.tnew_m, hif.waddr_w));
        chk("fwd_rs_e", 32'(hif.fwd_rs_e), fwd_exp(hif.rs_e, hif.waddr_m, hif.tnew_m, hif.waddr_w));
        chk("fwd_rt_e", 32'(hif.fwd_rt_e), fwd_exp(hif.rt_e, hif.waddr_m, hif.tnew_m, hif.waddr_w));
        chk("fwd_rt_m", 32'(hif.fwd_rt_m), 32'(hif.rt_m != 0 && hif.rt_m == hif.waddr_w));
        chk("mdu_busy", 32'(hif.mdu_busy), 32'(busy));
        chk("mdu_done", 32'(hif.mdu_done), 32'(model_done()));
        chk("stall_count", 32'(hif.stall_count), m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (hif.start_e && !model_busy()) begin
                op_valid = 1;
                op_start = edge_idx + 1;
                op_lat   = hif.is_div_e ? DIV_L : MUL_L;
            end
            edge_idx++;
            if (m_stall && m_count < SAT) m_count++;
        end
    endtask

    initial begin
        int stalls;
        int dones;
        int waited;
        set_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        chk("reset_busy", 32'(hif.mdu_busy), 0);
        chk("reset_count", 32'(hif.stall_count), 0);
        rst_n = 1'b1;

        // div then mflo waiting in D: stall in the start cycle plus the full latency
        @(negedge clk);
        hif.start_e = 1'b1; hif.is_div_e = 1'b1; hif.md_use_d = 1'b1;
        check_outputs();
        chk("div_start_stall", 32'(hif.stall_d), 1);
        stalls = int'(hif.stall_d);
        dones  = 0;
        tick();
        for (int i = 0; i < DIV_L; i++) begin
            @(negedge clk);
            hif.start_e = 1'b0;
            check_outputs();
            stalls += int'(hif.stall_d);
            dones  += int'(hif.mdu_done);
            tick();
        end
        @(negedge clk);
        check_outputs();
        chk("div_after_stall", 32'(hif.stall_d), 0);
        chk("div_stall_cycles", stalls, 1 + DIV_L);
        chk("div_done_pulses", dones, 1);
        tick();

        // lw r8 in E, add in D uses r8 next cycle
        @(negedge clk);
        set_idle();
        hif.rs_d = 5'd8; hif.tuse_rs_d = 2'd1; hif.waddr_e = 5'd8; hif.tnew_e = 2'd2;
        check_outputs();
        chk("lw_use_stall_d", 32'(hif.stall_d), 1);
        chk("lw_use_flush_e", 32'(hif.flush_e), 1);
        tick();
        @(negedge clk);
        hif.waddr_e = '0; hif.tnew_e = '0; hif.waddr_m = 5'd8; hif.tnew_m = 2'd1;
        check_outputs();
        chk("lw_use_released", 32'(hif.stall_d), 0);
        tick();
        @(negedge clk);
        set_idle();
        hif.rs_e = 5'd8; hif.waddr_w = 5'd8;
        check_outputs();
        chk("lw_use_fwd_w", 32'(hif.fwd_rs_e), 2);
        tick();

        // beq after addu: M forward, and r0 never forwards
        @(negedge clk);
        set_idle();
        hif.rs_d = 5'd3; hif.tuse_rs_d = 2'd0; hif.waddr_m = 5'd3; hif.tnew_m = 2'd0;
        check_outputs();
        chk("beq_fwd_m", 32'(hif.fwd_rs_d), 1);
        chk("beq_no_stall", 32'(hif.stall_d), 0);
        tick();
        @(negedge clk);
        hif.rs_d = '0; hif.waddr_m = '0;
        check_outputs();
        chk("beq_r0_fwd", 32'(hif.fwd_rs_d), 0);
        tick();

        // M has priority over W; store data from W
        @(negedge clk);
        set_idle();
        hif.rt_e = 5'd5; hif.waddr_m = 5'd5; hif.tnew_m = 2'd0; hif.waddr_w = 5'd5;
        check_outputs();
        chk("rt_e_m_wins", 32'(hif.fwd_rt_e), 1);
        tick();
        @(negedge clk);
        set_idle();
        hif.rt_m = 5'd7; hif.waddr_w = 5'd7;
        check_outputs();
        chk("store_fwd_w", 32'(hif.fwd_rt_m), 1);
        tick();

        // async reset in the middle of a mult
        @(negedge clk);
        set_idle();
        hif.start_e = 1'b1; hif.is_div_e = 1'b0;
        check_outputs();
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            hif.start_e = 1'b0;
            check_outputs();
            tick();
        end
        @(negedge clk);
        check_outputs();
        chk("mult_busy_cnt3", 32'(hif.mdu_busy), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_busy", 32'(hif.mdu_busy), 0);
        chk("rst_mid_done", 32'(hif.mdu_done), 0);
        chk("rst_mid_count", 32'(hif.stall_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        tick();

        // held data stall must saturate the counter, not wrap
        for (int i = 0; i < SAT + 6; i++) begin
            @(negedge clk);
            set_idle();
            hif.rt_d = 5'd2; hif.tuse_rt_d = 2'd0; hif.waddr_e = 5'd2; hif.tnew_e = 2'd1;
            check_outputs();
            tick();
        end
        @(negedge clk);
        #1;
        chk("count_saturated", 32'(hif.stall_count), SAT);

        // randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c % 150 == 149) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            hif.rs_d      = 5'($urandom_range(0, 7));
            hif.rt_d      = 5'($urandom_range(0, 7));
            hif.tuse_rs_d = 2'($urandom_range(0, 3));
            hif.tuse_rt_d = 2'($urandom_range(0, 3));
            hif.md_use_d  = 1'($urandom_range(0, 1));
            hif.rs_e      = 5'($urandom_range(0, 7));
            hif.rt_e      = 5'($urandom_range(0, 7));
            hif.waddr_e   = 5'($urandom_range(0, 7));
            hif.tnew_e    = 2'($urandom_range(0, 3));
            hif.rt_m      = 5'($urandom_range(0, 7));
            hif.waddr_m   = 5'($urandom_range(0, 7));
            hif.tnew_m    = 2'($urandom_range(0, 2));
            hif.waddr_w   = 5'($urandom_range(0, 7));
            hif.start_e   = ($urandom_range(0, 9) == 0);
            hif.is_div_e  = 1'($urandom_range(0, 1));
            check_outputs();
            tick();
        end

        // drain the MDU within a bounded number of cycles
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        waited = 0;
        while (hif.mdu_busy && waited < 20) begin
            check_outputs();
            tick();
            @(negedge clk);
            waited++;
        end
        chk("drain_idle", 32'(hif.mdu_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
